// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer: converts bit-reversed FFT frames to natural order via ping-pong banks
//
// Ports:
//   clock      in   master clock, rising edge
//   reset      in   asynchronous active-low reset
//   idata_en   in   input sample valid
//   idata_r/i  in   input sample (real/imag), bit-reversed frame order
//   odata_en   out  output sample valid, N contiguous cycles per frame
//   odata_r/i  out  output sample (real/imag), natural frame order
//   odata_sof  out  start-of-frame marker, present only with FFT_REORDER_SOF_EN defined
//
// Optional feature macro: FFT_REORDER_SOF_EN
module fft_reorder_buffer #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
`ifdef FFT_REORDER_SOF_EN
    ,
    output logic             odata_sof
`endif
);
    localparam int N = 1 << LOG2N;

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, waddr;
    logic               wbank_q, wbank_d, rbank_q, rbank_d;
    logic               start_q, start_d, sbank_q, sbank_d;
    logic               rd_en, wrap;
    logic               rd_vld_q, rd_vld_d, rsel_q, rsel_d;
    logic [2*WIDTH-1:0] mem0 [N];
    logic [2*WIDTH-1:0] mem1 [N];
    logic [2*WIDTH-1:0] rd0_q, rd1_q, rd_word;
    logic               odata_en_q, odata_en_d;
    logic [WIDTH-1:0]   odata_r_q, odata_r_d, odata_i_q, odata_i_d;

    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign waddr[i] = wcnt_q[LOG2N-1-i];
    end

    // Write side: frame boundary is purely the sample count wrapping
    always_comb begin
        wrap    = idata_en && (&wcnt_q);
        wcnt_d  = idata_en ? wcnt_q + 1'b1 : wcnt_q;
        wbank_d = wbank_q ^ wrap;
        start_d = wrap;
        sbank_d = wrap ? wbank_q : sbank_q;
    end

    // Read FSM: a start pulse on the last read address chains the next frame gaplessly
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        rd_en   = state_q == READ;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = READ;
                    rcnt_d  = '0;
                    rbank_d = sbank_q;
                end
            end
            READ: begin
                rcnt_d = rcnt_q + 1'b1;
                if (&rcnt_q) begin
                    if (start_q) begin
                        rcnt_d  = '0;
                        rbank_d = sbank_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output pipeline: RAM read stage, then output register
    always_comb begin
        rd_vld_d   = rd_en;
        rsel_d     = rbank_q;
        rd_word    = rsel_q ? rd1_q : rd0_q;
        odata_en_d = rd_vld_q;
        odata_r_d  = rd_vld_q ? rd_word[2*WIDTH-1:WIDTH] : '0;
        odata_i_d  = rd_vld_q ? rd_word[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            start_q    <= 1'b0;
            sbank_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rsel_q     <= 1'b0;
            odata_en_q <= 1'b0;
            odata_r_q  <= '0;
            odata_i_q  <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            start_q    <= start_d;
            sbank_q    <= sbank_d;
            rd_vld_q   <= rd_vld_d;
            rsel_q     <= rsel_d;
            odata_en_q <= odata_en_d;
            odata_r_q  <= odata_r_d;
            odata_i_q  <= odata_i_d;
        end
    end

    // Bank RAMs: no reset so they map onto block RAM
    always_ff @(posedge clock) begin
        if (idata_en && !wbank_q) mem0[waddr] <= {idata_r, idata_i};
        if (idata_en && wbank_q) mem1[waddr] <= {idata_r, idata_i};
        if (rd_en) rd0_q <= mem0[rcnt_q];
        if (rd_en) rd1_q <= mem1[rcnt_q];
    end

    assign odata_en = odata_en_q;
    assign odata_r  = odata_r_q;
    assign odata_i  = odata_i_q;

`ifdef FFT_REORDER_SOF_EN
    logic rd_sof_q, rd_sof_d, odata_sof_q, odata_sof_d;

    always_comb begin
        rd_sof_d    = rd_en && (rcnt_q == '0);
        odata_sof_d = rd_sof_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_sof_q    <= 1'b0;
            odata_sof_q <= 1'b0;
        end else begin
            rd_sof_q    <= rd_sof_d;
            odata_sof_q <= odata_sof_d;
        end
    end

    assign odata_sof = odata_sof_q;
`endif

`ifndef SYNTHESIS
    // A write at the address being read this same edge is safe: the read captures the old word
    always_ff @(posedge clock) begin
        if (reset && idata_en && state_q == READ && wbank_q == rbank_q)
            assert (waddr <= rcnt_q)
            else $error("fft_reorder_buffer: overwrite of unread entry %0d (read at %0d)", waddr, rcnt_q);
    end
`endif
endmodule
